// File: rtl/inv_key_expansion.sv
// AES-128 reverse key schedule: starting from the round-10 key, emits round
// keys 10 down to 0 over a valid/ready handshake, one key per transfer.

module s_box (
    input  logic [7:0] data,
    output logic [7:0] sub
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254 (254 = 8'b1111_1110); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] result;
        logic [7:0] p;
        result = 8'h01;
        p      = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) result = gf_mul(result, p);
            p = gf_mul(p, p);
        end
        return result;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    assign sub = affine(gf_inv(data));
endmodule

module key_expansion_g (
    input  logic [31:0] word,
    input  logic [31:0] rcon,
    output logic [31:0] g_word
);
    logic [31:0] rot;
    logic [31:0] subw;

    assign rot = {word[23:0], word[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        s_box u_sbox (
            .data(rot[8*i +: 8]),
            .sub (subw[8*i +: 8])
        );
    end

    assign g_word = subw ^ rcon;
endmodule

module inv_key_expansion (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy,
    output logic         done
);
    typedef enum logic {IDLE, EMIT} state_t;

    state_t       state;
    state_t       state_next;
    logic [127:0] key_next;
    logic [3:0]   round_next;
    logic         valid_next;
    logic         done_next;
    logic         xfer;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  p0, p1, p2, p3;
    logic [31:0]  rcon;
    logic [31:0]  g_word;
    logic [127:0] prev_key;

    assign xfer = rk_valid && rk_ready;

    assign w0 = rk_out[127:96];
    assign w1 = rk_out[95:64];
    assign w2 = rk_out[63:32];
    assign w3 = rk_out[31:0];

    // Undo the forward recurrence w[i] = w[i-4] ^ w[i-1]; word 0 needs g()
    // of the recovered previous word 3 with this round's Rcon.
    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;
    assign p0 = w0 ^ g_word;
    assign prev_key = {p0, p1, p2, p3};

    always_comb begin
        rcon = 32'h0;
        case (rk_round)
            4'd1:  rcon = 32'h01000000;
            4'd2:  rcon = 32'h02000000;
            4'd3:  rcon = 32'h04000000;
            4'd4:  rcon = 32'h08000000;
            4'd5:  rcon = 32'h10000000;
            4'd6:  rcon = 32'h20000000;
            4'd7:  rcon = 32'h40000000;
            4'd8:  rcon = 32'h80000000;
            4'd9:  rcon = 32'h1b000000;
            4'd10: rcon = 32'h36000000;
            default: rcon = 32'h0;
        endcase
    end

    key_expansion_g u_g (
        .word  (p3),
        .rcon  (rcon),
        .g_word(g_word)
    );

    always_comb begin
        state_next = state;
        key_next   = rk_out;
        round_next = rk_round;
        valid_next = rk_valid;
        done_next  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    key_next   = key_in;
                    round_next = 4'd10;
                    valid_next = 1'b1;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (xfer) begin
                    if (rk_round != 4'd0) begin
                        key_next   = prev_key;
                        round_next = rk_round - 4'd1;
                    end else begin
                        valid_next = 1'b0;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rk_out   <= '0;
            rk_round <= '0;
            rk_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            rk_out   <= key_next;
            rk_round <= round_next;
            rk_valid <= valid_next;
            done     <= done_next;
        end
    end
endmodule

// File: tb/tb_inv_key_expansion.sv
// Bench for inv_key_expansion: expected round keys come from a forward AES-128
// key expansion model built on an S-box table derived by brute-force inversion.

module tb_inv_key_expansion;
    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         rk_ready;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   sbox [0:255];
    logic [127:0] exp_rk [0:10];

    inv_key_expansion dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .key_in  (key_in),
        .rk_out  (rk_out),
        .rk_round(rk_round),
        .rk_valid(rk_valid),
        .rk_ready(rk_ready),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    function automatic void build_sbox();
        for (int v = 0; v < 256; v++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] b;
            for (int c = 1; c < 256; c++)
                if (mul(8'(v), 8'(c)) == 8'h01) inv = 8'(c);
            b = inv;
            sbox[v] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                        ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endfunction

    function automatic void expand(input logic [127:0] k0);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++)
            exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; rk_ready = 1'b0; key_in = '0;
        step(); step();
        n_checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            rk_round !== 4'd0 || rk_out !== 128'h0) begin
            n_fail++;
            $display("FAIL reset: valid=%b busy=%b done=%b round=%0d out=%h, want all zero",
                     rk_valid, busy, done, rk_round, rk_out);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: valid=%b busy=%b, want 0 0", rk_valid, busy);
        end
    endtask

    task automatic test_fips();
        logic [127:0] k0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        expand(k0);
        key_in = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6; start = 1'b1; rk_ready = 1'b1;
        step();
        start = 1'b0;
        for (int r = 10; r >= 0; r--) begin
            n_checks++;
            if (rk_valid !== 1'b1 || busy !== 1'b1 || rk_round !== 4'(r) || rk_out !== exp_rk[r]) begin
                n_fail++;
                $display("FAIL fips_r%0d: valid=%b busy=%b round=%0d out=%h, want 1 1 %0d %h",
                         r, rk_valid, busy, rk_round, rk_out, r, exp_rk[r]);
            end
            if (r == 10 || r == 9 || r == 0) begin
                logic [127:0] lit;
                lit = (r == 10) ? 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 :
                      (r == 9)  ? 128'hac7766f319fadc2128d12941575c006e :
                                  128'h2b7e151628aed2a6abf7158809cf4f3c;
                n_checks++;
                if (rk_out !== lit) begin
                    n_fail++;
                    $display("FAIL fips_vector_r%0d: out=%h, want %h", r, rk_out, lit);
                end
            end
            step();
        end
        n_checks++;
        if (done !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0 || rk_out !== k0) begin
            n_fail++;
            $display("FAIL fips_done: done=%b valid=%b busy=%b out=%h, want 1 0 0 %h",
                     done, rk_valid, busy, rk_out, k0);
        end
        rk_ready = 1'b0;
        step();
        n_checks++;
        if (done !== 1'b0 || rk_out !== k0) begin
            n_fail++;
            $display("FAIL fips_done_pulse: done=%b out=%h, want 0 %h", done, rk_out, k0);
        end
    endtask

    task automatic test_backpressure();
        int  r = 10;
        int  cyc = 0;
        logic xfer;
        expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        key_in = exp_rk[10]; start = 1'b1;
        step();
        start = 1'b0;
        while (r >= 0 && cyc < 400) begin
            rk_ready = 1'($urandom_range(0, 1));
            n_checks++;
            if (rk_valid !== 1'b1 || rk_round !== 4'(r) || rk_out !== exp_rk[r] || done !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_r%0d: valid=%b round=%0d out=%h done=%b, want 1 %0d %h 0",
                         r, rk_valid, rk_round, rk_out, done, r, exp_rk[r]);
            end
            xfer = rk_ready;
            step();
            if (xfer) r--;
            cyc++;
        end
        rk_ready = 1'b0;
        n_checks++;
        if (r >= 0) begin
            n_fail++;
            $display("FAIL backpressure_timeout: round left=%0d, want all transferred", r);
        end else if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_done: done=%b, want 1", done);
        end
        step();
    endtask

    task automatic test_start_during_emit();
        expand({$urandom, $urandom, $urandom, $urandom});
        key_in = exp_rk[10]; start = 1'b1; rk_ready = 1'b1;
        step();
        start = 1'b0;
        for (int r = 10; r >= 0; r--) begin
            n_checks++;
            if (rk_valid !== 1'b1 || rk_round !== 4'(r) || rk_out !== exp_rk[r]) begin
                n_fail++;
                $display("FAIL start_in_emit_r%0d: valid=%b round=%0d out=%h, want 1 %0d %h",
                         r, rk_valid, rk_round, rk_out, r, exp_rk[r]);
            end
            start  = (r == 5);
            key_in = ~exp_rk[10];
            step();
            start = 1'b0;
        end
        n_checks++;
        if (done !== 1'b1 || rk_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL start_in_emit_done: done=%b valid=%b, want 1 0", done, rk_valid);
        end
        rk_ready = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        expand({$urandom, $urandom, $urandom, $urandom});
        key_in = exp_rk[10]; start = 1'b1; rk_ready = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 6; k++) step();
        n_checks++;
        if (rk_round !== 4'd4 || rk_out !== exp_rk[4]) begin
            n_fail++;
            $display("FAIL reset_mid_pre: round=%0d out=%h, want 4 %h", rk_round, rk_out, exp_rk[4]);
        end
        rst = 1'b1; start = 1'b1;
        step();
        n_checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b0 || rk_round !== 4'd0 || rk_out !== 128'h0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: valid=%b busy=%b round=%0d out=%h done=%b, want 0 0 0 0 0",
                     rk_valid, busy, rk_round, rk_out, done);
        end
        rst = 1'b0; start = 1'b0;
        step();
        n_checks++;
        if (done !== 1'b0 || rk_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_nodone: done=%b valid=%b, want 0 0", done, rk_valid);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int r = 10; r >= 0; r--) begin
            n_checks++;
            if (rk_valid !== 1'b1 || rk_round !== 4'(r) || rk_out !== exp_rk[r]) begin
                n_fail++;
                $display("FAIL reset_mid_restart_r%0d: valid=%b round=%0d out=%h, want 1 %0d %h",
                         r, rk_valid, rk_round, rk_out, r, exp_rk[r]);
            end
            step();
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_restart_done: done=%b, want 1", done);
        end
        rk_ready = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [127:0] second;
        expand({$urandom, $urandom, $urandom, $urandom});
        second = exp_rk[10];
        expand({$urandom, $urandom, $urandom, $urandom});
        key_in = exp_rk[10]; start = 1'b1; rk_ready = 1'b1;
        step();
        start = 1'b0;
        for (int r = 10; r >= 0; r--) step();
        n_checks++;
        if (done !== 1'b1 || rk_out !== exp_rk[0]) begin
            n_fail++;
            $display("FAIL b2b_first_done: done=%b out=%h, want 1 %h", done, rk_out, exp_rk[0]);
        end
        key_in = second; start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if (rk_valid !== 1'b1 || busy !== 1'b1 || rk_round !== 4'd10 || rk_out !== second || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_restart: valid=%b busy=%b round=%0d out=%h done=%b, want 1 1 10 %h 0",
                     rk_valid, busy, rk_round, rk_out, done, second);
        end
        for (int r = 10; r >= 0; r--) step();
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second_done: done=%b, want 1", done);
        end
        rk_ready = 1'b0;
        step();
    endtask

    task automatic test_roundtrip();
        logic [127:0] k0;
        for (int n = 0; n < 100; n++) begin
            k0 = {$urandom, $urandom, $urandom, $urandom};
            expand(k0);
            key_in = exp_rk[10]; start = 1'b1; rk_ready = 1'b1;
            step();
            start = 1'b0;
            for (int r = 10; r > 0; r--) step();
            n_checks++;
            if (rk_valid !== 1'b1 || rk_round !== 4'd0 || rk_out !== k0) begin
                n_fail++;
                $display("FAIL roundtrip_%0d: valid=%b round=%0d out=%h, want 1 0 %h",
                         n, rk_valid, rk_round, rk_out, k0);
            end
            step();
            n_checks++;
            if (done !== 1'b1) begin
                n_fail++;
                $display("FAIL roundtrip_done_%0d: done=%b, want 1", n, done);
            end
        end
        rk_ready = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rk_ready = 1'b0; key_in = '0;
        build_sbox();
        test_reset();
        test_fips();
        test_backpressure();
        test_start_during_emit();
        test_reset_mid();
        test_back_to_back();
        test_roundtrip();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/inv_key_expansion.md
INV_KEY_EXPANSION -- requirements
Module: inv_key_expansion

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit, with synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 The block SHALL have the port start, input, 1 bit, a one-cycle request to begin reverse expansion; it is ignored unless the state is IDLE.
REQ-004 The block SHALL have the port key_in, input, 128 bits, the AES-128 round-10 key, with w40 at [127:96] and w43 at [31:0]; it is sampled only when start is accepted.
REQ-005 The block SHALL have the port rk_out, output, 128 bits, the current round key, in the same word order as key_in.
REQ-006 The block SHALL have the port rk_round, output, 4 bits, the round index of rk_out, 10 down to 0.
REQ-007 The block SHALL have the port rk_valid, output, 1 bit, which is high while rk_out/rk_round hold a round key not yet consumed.
REQ-008 The block SHALL have the port rk_ready, input, 1 bit, the consumer acceptance; a transfer occurs on a cycle with rk_valid and rk_ready both high.
REQ-009 The block SHALL have the port busy, output, 1 bit, which is high in every state other than IDLE.
REQ-010 The block SHALL have the port done, output, 1 bit, a one-cycle pulse on the cycle after the round-0 key transfers.

Function
REQ-011 The state machine SHALL have two states: IDLE and EMIT.
REQ-012 In IDLE with start=1, on the next edge the block SHALL load key_in into the key register, set rk_round=10, set rk_valid=1 and move to EMIT.
REQ-013 In EMIT, on a transfer with rk_round>0, the block SHALL replace the key register with the previous-round key, decrement rk_round and hold rk_valid=1.
REQ-014 In EMIT, on a transfer with rk_round=0, the block SHALL clear rk_valid, pulse done for one cycle and return to IDLE.
REQ-015 In EMIT without a transfer (rk_ready=0), rk_out, rk_round and rk_valid SHALL hold unchanged.
REQ-016 The previous-round key computation, for current words W0..W3 at round r, SHALL be:
- P3 = W3^W2
- P2 = W2^W1
- P1 = W1^W0
- P0 = W0 ^ g(P3, Rcon[r])
REQ-017 g SHALL be the existing key-expansion g function (instantiated, not re-coded): RotWord as a left rotate by one byte, SubWord via four S_BOX instances, then a 32-bit XOR with Rcon.
REQ-018 Rcon[r] SHALL be {rc,24'h0}, with rc for r=1..10 being 01,02,04,08,10,20,40,80,1B,36; it is selected combinationally from rk_round.
REQ-019 The next key SHALL be computed combinationally from the key register and registered on the transfer edge, giving a one-transfer-per-cycle throughput.
REQ-020 Latency SHALL be as follows: start accepted at edge N gives round-10 rk_valid after edge N; with rk_ready held at 1, round 0 is presented after edge N+10 and done is high after edge N+11.
REQ-021 start asserted during EMIT SHALL be ignored, with no reload and no effect on the sequence.
REQ-022 start on the same cycle the done pulse is high SHALL be accepted, since the state is already IDLE.
REQ-023 rk_out SHALL keep the round-0 key in IDLE until the next load.

Reset
REQ-024 When rst=1, on the next edge the state SHALL become IDLE, with rk_valid=0, done=0, busy=0, rk_round=0 and rk_out=0.
REQ-025 Reset SHALL take priority over start and over any transfer.
REQ-026 Reset mid-sequence SHALL abandon the sequence with no done pulse.

Verification
REQ-027 The bench SHALL cover a FIPS-197 A.1 check: key_in=d014f9a8c9ee2589e13f0cc8b6630ca6, start pulse, rk_ready=1 -> outputs in order:
- round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6
- round 9 = ac7766f319fadc2128d12941575c006e
- round 0 = 2b7e151628aed2a6abf7158809cf4f3c
- done one cycle after round 0.
REQ-028 The bench SHALL cover backpressure: same key, rk_ready toggled pseudo-randomly -> identical 11-key sequence, and values are stable while rk_valid=1 and rk_ready=0.
REQ-029 The bench SHALL cover start during EMIT: a second start with a different key at round 5 -> the sequence continues unchanged through round 0.
REQ-030 The bench SHALL cover reset mid-operation: rst at round 4 -> next cycle rk_valid=0, busy=0, rk_round=0, no done pulse; a subsequent start restarts correctly at round 10.
REQ-031 The bench SHALL cover back-to-back runs: start on the done cycle -> a new round 10 appears on the next edge.
REQ-032 The bench SHALL cover round-trip: forward-expand a random key, feed its round-10 key -> round 0 equals the original key, for 100 random keys.
